// File: rtl/core_ctrl_pkg.sv
// Shared types and instruction-word layout for the core_ctrl tile sequencer.
// Field positions mirror the 64-bit inst bus consumed by core.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_RD,
        S_W_LD,
        S_W_WAIT,
        S_ACT,
        S_DR_WAIT,
        S_DR_RD,
        S_DR_WR,
        S_DONE
    } state_t;

    localparam int INST_W = 64;
    localparam int ADDR_W = 11;
    localparam int PH_W   = 12;

    localparam int B_LOAD        = 0;
    localparam int B_EXECUTE     = 1;
    localparam int B_L0_WR       = 2;
    localparam int B_L0_RD       = 3;
    localparam int B_OFIFO_RD    = 6;
    localparam int A_XMEM_LO     = 7;
    localparam int A_XMEM_HI     = 17;
    localparam int B_WEN_XMEM    = 18;
    localparam int B_CEN_XMEM    = 19;
    localparam int A_PMEM_LO     = 20;
    localparam int A_PMEM_HI     = 30;
    localparam int B_WEN_PMEM    = 31;
    localparam int B_CEN_PMEM    = 32;
    localparam int B_ACC         = 33;
    localparam int B_PASSTHROUGH = 34;
    localparam int B_REN_PMEM    = 35;

    // Both CENs and WENs deasserted (high), everything else low.
    localparam logic [INST_W-1:0] INST_IDLE = 64'h0000_0001_800C_0000;

endpackage

// File: rtl/core_ctrl.sv
// Weight-stationary tile sequencer: weight load, activation stream/execute,
// then OFIFO drain into PSUM SRAM. inst/busy/done are all registered.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int row = 8,
    parameter int col = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic [ADDR_W-1:0] n_act,
    input  logic              acc_en,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    localparam logic [PH_W-1:0] ROW_L = PH_W'(row);
    localparam logic [PH_W-1:0] COL_L = PH_W'(col);

    state_t            state, state_n;
    logic [PH_W-1:0]   phase, phase_n;
    logic [ADDR_W-1:0] w_base_q, x_base_q, p_base_q, n_act_q;
    logic [ADDR_W-1:0] w_base_n, x_base_n, p_base_n, n_act_n;
    logic              acc_en_q, acc_en_n;
    logic [PH_W-1:0]   n_act_e;

    // Word for a given (state, phase); phase doubles as the drain index j.
    function automatic logic [INST_W-1:0] build_word(
        input state_t            s,
        input logic [PH_W-1:0]   ph,
        input logic [ADDR_W-1:0] wb,
        input logic [ADDR_W-1:0] xb,
        input logic [ADDR_W-1:0] pb,
        input logic [ADDR_W-1:0] na,
        input logic              ae
    );
        logic [INST_W-1:0] w;
        logic [PH_W-1:0]   na_e;
        w    = INST_IDLE;
        na_e = {1'b0, na};
        case (s)
            S_W_RD: begin
                if (ph < ROW_L) begin
                    w[B_CEN_XMEM]            = 1'b0;
                    w[A_XMEM_HI:A_XMEM_LO]   = wb + ph[ADDR_W-1:0];
                end
                if (ph != '0) w[B_L0_WR] = 1'b1;
            end
            S_W_LD: begin
                w[B_L0_RD] = 1'b1;
                w[B_LOAD]  = 1'b1;
            end
            S_ACT: begin
                if (ph < na_e) begin
                    w[B_CEN_XMEM]            = 1'b0;
                    w[A_XMEM_HI:A_XMEM_LO]   = xb + ph[ADDR_W-1:0];
                end
                if (ph >= 12'd1 && ph <= na_e) w[B_L0_WR] = 1'b1;
                if (ph >= 12'd2 && ph <= na_e + 12'd1) begin
                    w[B_L0_RD]   = 1'b1;
                    w[B_EXECUTE] = 1'b1;
                end
            end
            S_DR_RD: begin
                w[B_CEN_PMEM]          = 1'b0;
                w[B_REN_PMEM]          = 1'b1;
                w[A_PMEM_HI:A_PMEM_LO] = pb + ph[ADDR_W-1:0];
            end
            S_DR_WR: begin
                w[B_CEN_PMEM]          = 1'b0;
                w[B_WEN_PMEM]          = 1'b0;
                w[A_PMEM_HI:A_PMEM_LO] = pb + ph[ADDR_W-1:0];
                w[B_ACC]               = ae;
                w[B_OFIFO_RD]          = 1'b1;
            end
            default: ;
        endcase
        w[B_PASSTHROUGH] = 1'b0;
        return w;
    endfunction

    assign n_act_e = {1'b0, n_act_q};

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        w_base_n = w_base_q;
        x_base_n = x_base_q;
        p_base_n = p_base_q;
        n_act_n  = n_act_q;
        acc_en_n = acc_en_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n  = S_W_RD;
                    phase_n  = '0;
                    w_base_n = w_base;
                    x_base_n = x_base;
                    p_base_n = p_base;
                    n_act_n  = n_act;
                    acc_en_n = acc_en;
                end
            end
            S_W_RD: begin
                if (phase == ROW_L) begin
                    state_n = S_W_LD;
                    phase_n = '0;
                end else phase_n = phase + 12'd1;
            end
            S_W_LD: begin
                if (phase == ROW_L - 12'd1) begin
                    state_n = S_W_WAIT;
                    phase_n = '0;
                end else phase_n = phase + 12'd1;
            end
            S_W_WAIT: begin
                if (phase == COL_L - 12'd1) begin
                    state_n = (n_act_q == '0) ? S_DONE : S_ACT;
                    phase_n = '0;
                end else phase_n = phase + 12'd1;
            end
            S_ACT: begin
                if (phase == n_act_e + 12'd1) begin
                    state_n = S_DR_WAIT;
                    phase_n = '0;
                end else phase_n = phase + 12'd1;
            end
            S_DR_WAIT: if (ofifo_valid) state_n = S_DR_RD;
            S_DR_RD:   state_n = S_DR_WR;
            S_DR_WR: begin
                phase_n = phase + 12'd1;
                state_n = (phase_n == n_act_e) ? S_DONE : S_DR_WAIT;
            end
            S_DONE: begin
                state_n = S_IDLE;
                phase_n = '0;
            end
            default: begin
                state_n = S_IDLE;
                phase_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            phase    <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            n_act_q  <= '0;
            acc_en_q <= 1'b0;
            inst     <= INST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            w_base_q <= w_base_n;
            x_base_q <= x_base_n;
            p_base_q <= p_base_n;
            n_act_q  <= n_act_n;
            acc_en_q <= acc_en_n;
            inst     <= build_word(state_n, phase_n, w_base_n, x_base_n,
                                   p_base_n, n_act_n, acc_en_n);
            busy     <= (state_n != S_IDLE);
            done     <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: observes the inst stream each cycle and checks
// addresses, control strobes and tile timing against hand-computed values.
module tb_core_ctrl;

    localparam logic [63:0] IDLE_W = 64'h0000_0001_800C_0000;

    logic        clk = 1'b0;
    logic        reset, start, acc_en, ofifo_valid;
    logic [10:0] w_base, x_base, p_base, n_act;
    logic [63:0] inst;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] xa_q[$];
    logic [10:0] pw_q[$];
    int done_cyc, n_done, exec_cnt, pcen_cnt, ren_cnt, pacc, stall_idle;
    int bad_bits, busy_bad;
    logic busy_after;

    core_ctrl #(.row(8), .col(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .x_base(x_base), .p_base(p_base), .n_act(n_act),
        .acc_en(acc_en), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Runs one tile from a start pulse; cycle 1 is the first busy cycle.
    task automatic run_tile(input logic [10:0] wb, input logic [10:0] xb,
                            input logic [10:0] pb, input logic [10:0] na,
                            input logic ae, input int stall, input int glitch_cyc);
        int cyc;
        xa_q.delete(); pw_q.delete();
        done_cyc = 0; n_done = 0; exec_cnt = 0; pcen_cnt = 0; ren_cnt = 0;
        pacc = 0; stall_idle = 0; bad_bits = 0; busy_bad = 0; busy_after = 1'b1;
        @(posedge clk); #1;
        w_base = wb; x_base = xb; p_base = pb; n_act = na; acc_en = ae;
        start = 1'b1; ofifo_valid = (stall == 0);
        @(posedge clk); #1;
        start = 1'b0;
        w_base = 11'h555; x_base = 11'h2AA; p_base = 11'h7FF; n_act = 11'd3; acc_en = ~ae;
        cyc = 0;
        while (cyc < 200 && (done_cyc == 0 || cyc < done_cyc + 6)) begin
            @(negedge clk);
            cyc++;
            if (!inst[19]) xa_q.push_back(inst[17:7]);
            if (inst[1]) exec_cnt++;
            if (!inst[32]) pcen_cnt++;
            if (!inst[32] && inst[35]) ren_cnt++;
            if (!inst[32] && !inst[31]) begin
                pw_q.push_back(inst[30:20]);
                if (inst[33]) pacc++;
            end
            if (inst[63:36] != 28'd0 || inst[34] || inst[5:4] != 2'd0) bad_bits++;
            if (done_cyc != 0 && cyc == done_cyc + 1) busy_after = busy;
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc == 0 && !busy) busy_bad++;
            if (stall > 0 && cyc >= 32 && cyc < 32 + stall && inst === IDLE_W) stall_idle++;
            ofifo_valid = (stall == 0) || (cyc >= 32 + stall);
            start = (cyc == glitch_cyc);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0; acc_en = 1'b0;
        w_base = '0; x_base = '0; p_base = '0; n_act = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (inst !== IDLE_W) begin n_fail++; $display("FAIL reset_inst got %h want %h", inst, IDLE_W); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_full_tile;
        logic [10:0] e;
        run_tile(11'd0, 11'd16, 11'd0, 11'd4, 1'b1, 0, -1);
        n_checks++; if (done_cyc !== 44) begin n_fail++; $display("FAIL full_done_cyc got %0d want 44", done_cyc); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL full_done_pulses got %0d want 1", n_done); end
        n_checks++; if (xa_q.size() !== 12) begin n_fail++; $display("FAIL full_xmem_count got %0d want 12", xa_q.size()); end
        for (int i = 0; i < 12 && i < xa_q.size(); i++) begin
            e = (i < 8) ? 11'(i) : 11'(16 + i - 8);
            n_checks++; if (xa_q[i] !== e) begin n_fail++; $display("FAIL full_xmem_addr[%0d] got %0d want %0d", i, xa_q[i], e); end
        end
        n_checks++; if (pw_q.size() !== 4) begin n_fail++; $display("FAIL full_pmem_wr_count got %0d want 4", pw_q.size()); end
        for (int i = 0; i < 4 && i < pw_q.size(); i++) begin
            n_checks++; if (pw_q[i] !== 11'(i)) begin n_fail++; $display("FAIL full_pmem_addr[%0d] got %0d want %0d", i, pw_q[i], i); end
        end
        n_checks++; if (pacc !== 4) begin n_fail++; $display("FAIL full_acc_count got %0d want 4", pacc); end
        n_checks++; if (exec_cnt !== 4) begin n_fail++; $display("FAIL full_execute_count got %0d want 4", exec_cnt); end
        n_checks++; if (ren_cnt !== 4) begin n_fail++; $display("FAIL full_pmem_rd_count got %0d want 4", ren_cnt); end
        n_checks++; if (bad_bits !== 0) begin n_fail++; $display("FAIL full_reserved_bits got %0d want 0", bad_bits); end
        n_checks++; if (busy_bad !== 0) begin n_fail++; $display("FAIL full_busy_gap got %0d want 0", busy_bad); end
        n_checks++; if (busy_after !== 1'b0) begin n_fail++; $display("FAIL full_busy_after got %b want 0", busy_after); end
    endtask

    task automatic test_ofifo_stall;
        run_tile(11'd0, 11'd16, 11'd0, 11'd4, 1'b1, 10, -1);
        n_checks++; if (done_cyc !== 54) begin n_fail++; $display("FAIL stall_done_cyc got %0d want 54", done_cyc); end
        n_checks++; if (stall_idle !== 10) begin n_fail++; $display("FAIL stall_idle_words got %0d want 10", stall_idle); end
        n_checks++; if (pw_q.size() !== 4) begin n_fail++; $display("FAIL stall_pmem_wr_count got %0d want 4", pw_q.size()); end
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL stall_done_pulses got %0d want 1", n_done); end
    endtask

    task automatic test_wrap_no_act;
        logic [10:0] e;
        run_tile(11'd2046, 11'd16, 11'd0, 11'd0, 1'b1, 0, -1);
        n_checks++; if (done_cyc !== 26) begin n_fail++; $display("FAIL wrap_done_cyc got %0d want 26", done_cyc); end
        n_checks++; if (xa_q.size() !== 8) begin n_fail++; $display("FAIL wrap_xmem_count got %0d want 8", xa_q.size()); end
        for (int i = 0; i < 8 && i < xa_q.size(); i++) begin
            e = (i < 2) ? 11'(2046 + i) : 11'(i - 2);
            n_checks++; if (xa_q[i] !== e) begin n_fail++; $display("FAIL wrap_xmem_addr[%0d] got %0d want %0d", i, xa_q[i], e); end
        end
        n_checks++; if (exec_cnt !== 0) begin n_fail++; $display("FAIL wrap_execute_count got %0d want 0", exec_cnt); end
        n_checks++; if (pcen_cnt !== 0) begin n_fail++; $display("FAIL wrap_pmem_cen_count got %0d want 0", pcen_cnt); end
    endtask

    task automatic test_reset_mid_act;
        logic [10:0] e;
        @(posedge clk); #1;
        w_base = 11'd0; x_base = 11'd16; p_base = 11'd0; n_act = 11'd4; acc_en = 1'b1;
        start = 1'b1; ofifo_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (28) @(negedge clk);
        n_checks++; if (inst[1] !== 1'b1) begin n_fail++; $display("FAIL midact_execute got %b want 1", inst[1]); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (inst !== IDLE_W) begin n_fail++; $display("FAIL midact_reset_inst got %h want %h", inst, IDLE_W); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midact_reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midact_reset_done got %b want 0", done); end
        @(posedge clk); #1 reset = 1'b0;
        run_tile(11'd0, 11'd16, 11'd0, 11'd4, 1'b1, 0, -1);
        n_checks++; if (done_cyc !== 44) begin n_fail++; $display("FAIL rerun_done_cyc got %0d want 44", done_cyc); end
        n_checks++; if (xa_q.size() !== 12) begin n_fail++; $display("FAIL rerun_xmem_count got %0d want 12", xa_q.size()); end
        for (int i = 0; i < 12 && i < xa_q.size(); i++) begin
            e = (i < 8) ? 11'(i) : 11'(16 + i - 8);
            n_checks++; if (xa_q[i] !== e) begin n_fail++; $display("FAIL rerun_xmem_addr[%0d] got %0d want %0d", i, xa_q[i], e); end
        end
    endtask

    task automatic test_start_ignored;
        logic [10:0] e;
        run_tile(11'd5, 11'd2045, 11'd2046, 11'd4, 1'b0, 0, 12);
        n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL busy_start_done_pulses got %0d want 1", n_done); end
        n_checks++; if (done_cyc !== 44) begin n_fail++; $display("FAIL busy_start_done_cyc got %0d want 44", done_cyc); end
        n_checks++; if (xa_q.size() !== 12) begin n_fail++; $display("FAIL busy_start_xmem_count got %0d want 12", xa_q.size()); end
        for (int i = 0; i < 12 && i < xa_q.size(); i++) begin
            e = (i < 8) ? 11'(5 + i) : 11'(2045 + i - 8);
            n_checks++; if (xa_q[i] !== e) begin n_fail++; $display("FAIL busy_start_xmem_addr[%0d] got %0d want %0d", i, xa_q[i], e); end
        end
        for (int i = 0; i < 4 && i < pw_q.size(); i++) begin
            e = 11'(2046 + i);
            n_checks++; if (pw_q[i] !== e) begin n_fail++; $display("FAIL busy_start_pmem_addr[%0d] got %0d want %0d", i, pw_q[i], e); end
        end
        n_checks++; if (pacc !== 0) begin n_fail++; $display("FAIL busy_start_acc_count got %0d want 0", pacc); end
    endtask

    initial begin
        test_reset;
        test_full_tile;
        test_ofifo_stall;
        test_wrap_no_act;
        test_reset_mid_act;
        test_start_ignored;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
